// File: rtl/stopwatch_lap_controller_pkg.sv
// Shared definitions for the stopwatch controller and its counter datapath:
// state encodings plus the tick-divider and register-width helpers.
package stopwatch_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_CLEARED  = 3'd0,
        ST_RUNNING  = 3'd1,
        ST_STOPPED  = 3'd2,
        ST_LAP_RUN  = 3'd3,
        ST_LAP_STOP = 3'd4
    } state_t;

    // Clocks per CountEnable tick.
    function automatic int calc_div(input int clock_hz, input int tick_hz);
        return clock_hz / tick_hz;
    endfunction

    // Bits needed to hold 0..n-1 (never less than one bit).
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stopwatch_lap_controller_if.sv
// Button inputs and control outputs of the stopwatch controller.
// master: the controller side; slave: board buttons plus counter/display side.
interface stopwatch_lap_controller_if;

    logic StartStop;
    logic LapReset;
    logic Run;
    logic Clear;
    logic CountEnable;
    logic Hold;
    logic LapCapture;
    logic Overflow;

    modport master (
        input  StartStop, LapReset,
        output Run, Clear, CountEnable, Hold, LapCapture, Overflow
    );

    modport slave (
        output StartStop, LapReset,
        input  Run, Clear, CountEnable, Hold, LapCapture, Overflow
    );

endinterface

// File: rtl/stopwatch_lap_controller_button_conditioner.sv
// Raw push-button conditioner: two-flop synchroniser, stable-level debounce
// filter (level must persist DEBOUNCE_CYCLES samples) and a rising-edge
// one-shot. A held button yields one pulse; a release yields none.
module button_conditioner
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_pulse
);

    localparam int              CW       = width_of(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;

    // Synchronise, count consecutive samples that disagree with the accepted level, accept on the last one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_pulse  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt    <= '0;
                r_stable <= r_sync2;
                r_pulse  <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/stopwatch_lap_controller.sv
// Stopwatch sequencing controller: conditions StartStop/LapReset, runs the
// five-state Moore FSM and drives Run/Clear/Hold/LapCapture plus the
// CountEnable prescaler. Optional auto-stop at MAX_TICKS is enabled by
// defining OVERFLOW_STOP_EN; otherwise Overflow is tied low.
module stopwatch_lap_controller
    import stopwatch_ctrl_pkg::*;
#(
    parameter int CLOCK_HZ        = 50_000_000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int MAX_TICKS       = 360_000
) (
    input  logic                          Clock,
    input  logic                          Reset,
    stopwatch_lap_controller_if.master    bus
);

    localparam int            DIV        = calc_div(CLOCK_HZ, TICK_HZ);
    localparam int            PW         = width_of(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic          w_ssp;
    logic          w_lrp;
    logic          w_ovf_hit;
    logic          w_ovf_block;
    state_t        r_state;
    state_t        w_state_next;
    logic          r_run;
    logic          r_clear;
    logic          r_hold;
    logic          r_lapcap;
    logic          r_ce;
    logic [PW-1:0] r_presc;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss_cond (
        .i_clk(Clock), .i_rst(Reset), .i_raw(bus.StartStop), .o_pulse(w_ssp)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lr_cond (
        .i_clk(Clock), .i_rst(Reset), .i_raw(bus.LapReset), .o_pulse(w_lrp)
    );

    // Next state: auto-stop beats buttons, StartStop beats LapReset.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CLEARED: begin
                if (w_ssp) w_state_next = ST_RUNNING;
                else       w_state_next = ST_CLEARED;
            end
            ST_RUNNING: begin
                if (w_ovf_hit)  w_state_next = ST_STOPPED;
                else if (w_ssp) w_state_next = ST_STOPPED;
                else if (w_lrp) w_state_next = ST_LAP_RUN;
                else            w_state_next = ST_RUNNING;
            end
            ST_LAP_RUN: begin
                if (w_ovf_hit)  w_state_next = ST_LAP_STOP;
                else if (w_ssp) w_state_next = ST_LAP_STOP;
                else if (w_lrp) w_state_next = ST_RUNNING;
                else            w_state_next = ST_LAP_RUN;
            end
            ST_STOPPED: begin
                if (w_ssp && !w_ovf_block) w_state_next = ST_RUNNING;
                else if (w_lrp)            w_state_next = ST_CLEARED;
                else                       w_state_next = ST_STOPPED;
            end
            ST_LAP_STOP: begin
                if (w_ssp && !w_ovf_block) w_state_next = ST_LAP_RUN;
                else if (w_lrp)            w_state_next = ST_STOPPED;
                else                       w_state_next = ST_LAP_STOP;
            end
            default: w_state_next = ST_CLEARED;
        endcase
    end

    // State register with Moore outputs registered from the next state so they track it exactly.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= ST_CLEARED;
            r_run    <= 1'b0;
            r_clear  <= 1'b1;
            r_hold   <= 1'b0;
            r_lapcap <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_run    <= (w_state_next == ST_RUNNING) || (w_state_next == ST_LAP_RUN);
            r_clear  <= (w_state_next == ST_CLEARED);
            r_hold   <= (w_state_next == ST_LAP_RUN) || (w_state_next == ST_LAP_STOP);
            r_lapcap <= (r_state == ST_RUNNING) && (w_state_next == ST_LAP_RUN);
        end
    end

    // Tick prescaler: advances only while running, keeps its phase while stopped, zeroed while cleared.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_presc <= '0;
            r_ce    <= 1'b0;
        end else if (r_clear) begin
            r_presc <= '0;
            r_ce    <= 1'b0;
        end else if (r_run) begin
            r_ce    <= (r_presc == PRESC_LAST);
            r_presc <= (r_presc == PRESC_LAST) ? '0 : (r_presc + PW'(1));
        end else begin
            r_ce    <= 1'b0;
            r_presc <= r_presc;
        end
    end

`ifdef OVERFLOW_STOP_EN
    localparam int            TW        = width_of(MAX_TICKS);
    localparam logic [TW-1:0] TICK_LAST = TW'(MAX_TICKS - 1);

    logic [TW-1:0] r_ticks;
    logic          r_overflow;

    assign w_ovf_hit   = r_ce && (r_ticks == TICK_LAST);
    assign w_ovf_block = r_overflow || w_ovf_hit;

    // Elapsed tick count since the last clear.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_ticks <= '0;
        end else if (r_clear) begin
            r_ticks <= '0;
        end else if (r_ce) begin
            r_ticks <= r_ticks + TW'(1);
        end else begin
            r_ticks <= r_ticks;
        end
    end

    // Sticky overflow flag, released only by returning to the cleared state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_overflow <= 1'b0;
        end else if (w_state_next == ST_CLEARED) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_hit) begin
            r_overflow <= 1'b1;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    assign bus.Overflow = r_overflow;
`else
    assign w_ovf_hit    = 1'b0;
    assign w_ovf_block  = 1'b0;
    assign bus.Overflow = 1'b0;
`endif

    assign bus.Run         = r_run;
    assign bus.Clear       = r_clear;
    assign bus.Hold        = r_hold;
    assign bus.LapCapture  = r_lapcap;
    assign bus.CountEnable = r_ce;

endmodule

// File: tb/tb_stopwatch_lap_controller.sv
// Self-checking bench for stopwatch_lap_controller. A behavioural model
// (mode flags, run-cycle count, raw-sample history) predicts every output
// each cycle; directed phases with randomized press timing plus a random soak.
module tb_stopwatch_lap_controller;

    localparam int CLOCK_HZ  = 8;
    localparam int TICK_HZ   = 2;
    localparam int DEB       = 3;
    localparam int MAX_TICKS = 5;
    localparam int DIV       = CLOCK_HZ / TICK_HZ;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    stopwatch_lap_controller_if sw_if();

    stopwatch_lap_controller #(
        .CLOCK_HZ(CLOCK_HZ), .TICK_HZ(TICK_HZ),
        .DEBOUNCE_CYCLES(DEB), .MAX_TICKS(MAX_TICKS)
    ) dut (
        .Clock(clk), .Reset(rst), .bus(sw_if)
    );

    always #5 clk = ~clk;

    // Model: visible outputs and the quantities they derive from.
    bit m_cleared, m_running, m_hold, m_lapcap, m_ce, m_ovf;
    int m_runcyc, m_ticks;
    logic [DEB+1:0] ss_hist, lr_hist;
    bit ss_stable, lr_stable, m_ssp, m_lrp;

    // Accept a new level once the synchronised samples in the window all agree on it.
    function automatic bit [1:0] deb_step(input logic [DEB+1:0] h, input bit stable);
        logic [DEB-1:0] w;
        w = h[DEB+1:2];
        if (w == '1 && !stable) return 2'b11;
        if (w == '0 && stable)  return 2'b00;
        return {stable, 1'b0};
    endfunction

    task automatic model_edge(input bit r, input bit ss, input bit lr);
        bit hit, cen, lapn, ssp_eff;
        bit [1:0] d;
        if (r) begin
            m_cleared = 1'b1; m_running = 1'b0; m_hold = 1'b0; m_lapcap = 1'b0;
            m_ce = 1'b0; m_ovf = 1'b0; m_runcyc = 0; m_ticks = 0;
            ss_hist = '0; lr_hist = '0; ss_stable = 1'b0; lr_stable = 1'b0;
            m_ssp = 1'b0; m_lrp = 1'b0;
            return;
        end
        hit = 1'b0;
        cen = 1'b0;
        if (m_running) begin
            m_runcyc++;
            cen = (m_runcyc % DIV == 0);
        end else if (m_cleared) begin
            m_runcyc = 0;
        end
`ifdef OVERFLOW_STOP_EN
        hit = m_ce && (m_ticks == MAX_TICKS - 1);
        if (m_cleared) m_ticks = 0;
        else if (m_ce) m_ticks++;
`endif
        lapn    = 1'b0;
        ssp_eff = m_ssp && !(!m_cleared && !m_running && (m_ovf || hit));
        if (hit && m_running) begin
            m_running = 1'b0;
        end else if (ssp_eff) begin
            if (m_cleared) begin m_cleared = 1'b0; m_running = 1'b1; end
            else m_running = !m_running;
        end else if (m_lrp) begin
            if (m_cleared) begin end
            else if (m_running && !m_hold) begin m_hold = 1'b1; lapn = 1'b1; end
            else if (m_hold) m_hold = 1'b0;
            else m_cleared = 1'b1;
        end
        if (hit) m_ovf = 1'b1;
        if (m_cleared) m_ovf = 1'b0;
        m_lapcap = lapn;
        m_ce     = cen;
        ss_hist = {ss_hist[DEB:0], ss};
        d = deb_step(ss_hist, ss_stable); ss_stable = d[1]; m_ssp = d[0];
        lr_hist = {lr_hist[DEB:0], lr};
        d = deb_step(lr_hist, lr_stable); lr_stable = d[1]; m_lrp = d[0];
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_bit("Run",         sw_if.Run,         m_running);
        check_bit("Clear",       sw_if.Clear,       m_cleared);
        check_bit("Hold",        sw_if.Hold,        m_hold);
        check_bit("LapCapture",  sw_if.LapCapture,  m_lapcap);
        check_bit("CountEnable", sw_if.CountEnable, m_ce);
        check_bit("Overflow",    sw_if.Overflow,    m_ovf);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare away from the edge.
    task automatic cyc(input bit r, input bit ss, input bit lr);
        rst = r;
        sw_if.StartStop = ss;
        sw_if.LapReset  = lr;
        @(posedge clk);
        model_edge(r, ss, lr);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press(input bit ss, input bit lr);
        int h;
        h = $urandom_range(5, 10);
        for (int i = 0; i < h; i++) cyc(1'b0, ss, lr);
        idle($urandom_range(5, 9));
    endtask

    initial begin
        int run_at, ce_at;
        sw_if.StartStop = 1'b0;
        sw_if.LapReset  = 1'b0;

        // 1: reset, then LapReset in CLEARED changes nothing
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check_bit("reset_clear", sw_if.Clear, 1'b1);
        check_bit("reset_run",   sw_if.Run,   1'b0);
        check_bit("reset_hold",  sw_if.Hold,  1'b0);
        check_bit("reset_ce",    sw_if.CountEnable, 1'b0);
        press(1'b0, 1'b1);
        check_bit("lr_in_cleared", sw_if.Clear, 1'b1);

        // 2: StartStop held 20 cycles: one start, first tick DIV cycles after Run
        run_at = -1;
        ce_at  = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            if (run_at < 0 && sw_if.Run === 1'b1) run_at = i;
            if (ce_at < 0 && run_at >= 0 && sw_if.CountEnable === 1'b1) ce_at = i;
        end
        check_int("first_tick_gap", ce_at - run_at, DIV);
        check_bit("run_after_hold", sw_if.Run, 1'b1);
        idle(3);

        // 3: lap capture, then lap release
        press(1'b0, 1'b1);
        idle($urandom_range(0, 6));
        press(1'b0, 1'b1);

        // 4: stop, wait, restart (phase kept), stop, LapReset clears
        idle($urandom_range(0, 3));
        press(1'b1, 1'b0);
        idle(10);
        press(1'b1, 1'b0);
        idle($urandom_range(2, 6));
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);

        // 5: both buttons together, then reset in the middle of a lap
        cyc(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        check_bit("reset_mid_lap_clear", sw_if.Clear, 1'b1);
        check_bit("reset_mid_lap_hold",  sw_if.Hold,  1'b0);

        // 6: run past MAX_TICKS ticks
        cyc(1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        idle(DIV * MAX_TICKS + 8);
`ifdef OVERFLOW_STOP_EN
        check_bit("ovf_autostop_run", sw_if.Run, 1'b0);
        check_bit("ovf_flag",         sw_if.Overflow, 1'b1);
        press(1'b1, 1'b0);
        check_bit("ovf_ss_ignored",   sw_if.Run, 1'b0);
`else
        check_bit("no_ovf_run", sw_if.Run, 1'b1);
        check_bit("no_ovf_flag", sw_if.Overflow, 1'b0);
        press(1'b1, 1'b0);
`endif
        press(1'b0, 1'b1);
        check_bit("ovf_cleared_state", sw_if.Clear, 1'b1);
        check_bit("ovf_cleared_flag",  sw_if.Overflow, 1'b0);

        // 7: random soak, including short glitches and occasional resets
        for (int seg = 0; seg < 80; seg++) begin
            bit s, l, r;
            int len;
            s   = 1'($urandom_range(0, 1));
            l   = 1'($urandom_range(0, 1));
            r   = ($urandom_range(0, 29) == 0);
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) cyc(r && (k == 0), s, l);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
